// File: rtl/am2910_microsequencer.sv
// Am2910-style microprogram sequencer: next-address selection, uPC,
// subroutine/loop stack and the loop/branch register-counter R.
module am2910_microsequencer #(
    parameter int AW    = 12,
    parameter int DEPTH = 5
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [3:0]    I,
    input  logic [AW-1:0] D,
    input  logic          CC_N,
    input  logic          CCEN_N,
    input  logic          CI,
    input  logic          RLD_N,
    output logic [AW-1:0] Y,
    output logic          FULL_N,
    output logic          PL_N,
    output logic          MAP_N,
    output logic          VECT_N
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    logic [AW-1:0]  upc_q, upc_d;
    logic [AW-1:0]  r_q, r_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           full_n_q, full_n_d;
    logic [AW-1:0]  stack_q [DEPTH];

    logic [AW-1:0]  tos;
    logic           pass, rz;
    logic           push_req, pop_req, clear;
    logic           push_ok, pop_ok;
    logic           r_dec, r_ld;

    assign pass = CCEN_N | ~CC_N;
    assign rz   = (r_q == '0);
    // An empty stack reads as address zero.
    assign tos  = (sp_q == '0) ? '0 : stack_q[sp_q - SPW'(1)];

    // Instruction decode: next address plus stack and counter side effects.
    always_comb begin
        Y        = upc_q;
        push_req = 1'b0;
        pop_req  = 1'b0;
        clear    = 1'b0;
        r_dec    = 1'b0;
        r_ld     = 1'b0;
        case (I)
            4'd0:  begin Y = '0; clear = 1'b1; end
            4'd1:  if (pass) begin Y = D; push_req = 1'b1; end
            4'd2:  Y = D;
            4'd3:  if (pass) Y = D;
            4'd4:  begin push_req = 1'b1; r_ld = pass; end
            4'd5:  begin push_req = 1'b1; Y = pass ? D : r_q; end
            4'd6:  if (pass) Y = D;
            4'd7:  Y = pass ? D : r_q;
            4'd8:  if (!rz) begin Y = tos; r_dec = 1'b1; end
                   else pop_req = 1'b1;
            4'd9:  if (!rz) begin Y = D; r_dec = 1'b1; end
            4'd10: if (pass) begin Y = tos; pop_req = 1'b1; end
            4'd11: if (pass) begin Y = D; pop_req = 1'b1; end
            4'd12: r_ld = 1'b1;
            4'd13: if (pass) pop_req = 1'b1;
                   else Y = tos;
            4'd14: Y = upc_q;
            4'd15: if (pass) pop_req = 1'b1;
                   else if (!rz) begin Y = tos; r_dec = 1'b1; end
                   else begin Y = D; pop_req = 1'b1; end
            default: Y = upc_q;
        endcase
    end

    // Next-state for uPC, R and the stack pointer; full/empty limits applied here.
    always_comb begin
        push_ok  = push_req && (sp_q != SP_FULL);
        pop_ok   = pop_req && (sp_q != '0);
        upc_d    = Y + {{(AW-1){1'b0}}, CI};
        r_d      = r_q;
        if (!RLD_N || r_ld) r_d = D;
        else if (r_dec)     r_d = r_q - AW'(1);
        sp_d     = sp_q;
        if (clear)        sp_d = '0;
        else if (push_ok) sp_d = sp_q + SPW'(1);
        else if (pop_ok)  sp_d = sp_q - SPW'(1);
        full_n_d = (sp_d != SP_FULL);
    end

    // Sequencer state registers, cleared asynchronously.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            upc_q    <= '0;
            r_q      <= '0;
            sp_q     <= '0;
            full_n_q <= 1'b1;
        end else begin
            upc_q    <= upc_d;
            r_q      <= r_d;
            sp_q     <= sp_d;
            full_n_q <= full_n_d;
        end
    end

    // Stack storage; contents are don't-care after reset since SP marks it empty.
    always_ff @(posedge CLK) begin
        if (push_ok) stack_q[sp_q] <= upc_q;
    end

    assign FULL_N = full_n_q;
    assign MAP_N  = (I != 4'd2);
    assign VECT_N = (I != 4'd6);
    assign PL_N   = (I == 4'd2) || (I == 4'd6);

endmodule

// File: tb/tb_am2910_microsequencer.sv
// Randomized and directed bench for am2910_microsequencer against a
// queue-based behavioural model of the next-address rules.
module tb_am2910_microsequencer;

    localparam int AW    = 12;
    localparam int DEPTH = 5;
    localparam int MASK  = (1 << AW) - 1;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [3:0]    I;
    logic [AW-1:0] D;
    logic          CC_N, CCEN_N, CI, RLD_N;
    logic [AW-1:0] Y;
    logic          FULL_N, PL_N, MAP_N, VECT_N;

    am2910_microsequencer #(.AW(AW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .I(I), .D(D), .CC_N(CC_N), .CCEN_N(CCEN_N),
        .CI(CI), .RLD_N(RLD_N), .Y(Y), .FULL_N(FULL_N), .PL_N(PL_N),
        .MAP_N(MAP_N), .VECT_N(VECT_N)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: plain integers and a queue for the stack.
    int m_upc;
    int m_r;
    int m_stk[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_tos();
        return (m_stk.size() == 0) ? 0 : m_stk[$];
    endfunction

    task automatic model_reset();
        m_upc = 0;
        m_r   = 0;
        m_stk.delete();
    endtask

    // Present one instruction (caller is at a negedge), check, clock, advance model.
    task automatic step(input int i, input int d, input bit cc_n, input bit ccen_n,
                        input bit ci, input bit rld_n, input string tag);
        int  y;
        int  r_new;
        bit  pass, rz, push, pop, clr;
        I = 4'(i); D = AW'(d); CC_N = cc_n; CCEN_N = ccen_n; CI = ci; RLD_N = rld_n;
        #1;
        pass  = ccen_n || !cc_n;
        rz    = (m_r == 0);
        push  = 0; pop = 0; clr = 0;
        r_new = m_r;
        y     = m_upc;
        case (i)
            0:  begin y = 0; clr = 1; end
            1:  if (pass) begin y = d; push = 1; end
            2:  y = d;
            3:  if (pass) y = d;
            4:  begin push = 1; if (pass) r_new = d; end
            5:  begin push = 1; y = pass ? d : m_r; end
            6:  if (pass) y = d;
            7:  y = pass ? d : m_r;
            8:  if (!rz) begin y = m_tos(); r_new = m_r - 1; end else pop = 1;
            9:  if (!rz) begin y = d; r_new = m_r - 1; end
            10: if (pass) begin y = m_tos(); pop = 1; end
            11: if (pass) begin y = d; pop = 1; end
            12: r_new = d;
            13: if (pass) pop = 1; else y = m_tos();
            14: y = m_upc;
            default: begin
                if (pass) pop = 1;
                else if (!rz) begin y = m_tos(); r_new = m_r - 1; end
                else begin y = d; pop = 1; end
            end
        endcase
        chk({tag, ".Y"}, int'(Y), y);
        chk({tag, ".FULL_N"}, int'(FULL_N), (m_stk.size() == DEPTH) ? 0 : 1);
        chk({tag, ".MAP_N"}, int'(MAP_N), (i == 2) ? 0 : 1);
        chk({tag, ".VECT_N"}, int'(VECT_N), (i == 6) ? 0 : 1);
        chk({tag, ".PL_N"}, int'(PL_N), (i == 2 || i == 6) ? 1 : 0);
        @(posedge CLK);
        if (!rld_n) r_new = d;
        if (clr) m_stk.delete();
        else if (push && m_stk.size() < DEPTH) m_stk.push_back(m_upc);
        else if (pop && m_stk.size() > 0) void'(m_stk.pop_back());
        m_r   = r_new;
        m_upc = (y + int'(ci)) & MASK;
        @(negedge CLK);
    endtask

    // Asynchronous reset mid-cycle; probes prove uPC, R and SP cleared before any edge.
    task automatic async_reset_probe(input string tag);
        #2;
        RESET = 1'b1;
        I = 4'd14; CI = 1'b1; RLD_N = 1'b1; CC_N = 1'b1; CCEN_N = 1'b0; D = 12'hABC;
        #1;
        chk({tag, ".upc0"}, int'(Y), 0);
        chk({tag, ".full_n"}, int'(FULL_N), 1);
        I = 4'd7;                               // JRP fail -> Y=R
        #1;
        chk({tag, ".r0"}, int'(Y), 0);
        I = 4'd10; CCEN_N = 1'b1;               // CRTN pass -> Y=TOS, empty reads 0
        #1;
        chk({tag, ".sp0"}, int'(Y), 0);
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; I = 4'd14; D = '0; CC_N = 1'b1; CCEN_N = 1'b1; CI = 1'b1; RLD_N = 1'b1;
        model_reset();
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        // Sequential fetch from reset.
        for (int k = 0; k < 4; k++) step(14, 0, 1, 1, 1, 1, "cont");
        chk("cont.upc4", int'(Y), 4);
        step(14, 0, 1, 1, 1, 1, "cont5");

        // Call and return, then a failing call.
        step(1, 12'h100, 0, 0, 1, 1, "cjs");
        step(10, 0, 0, 0, 1, 1, "crtn");
        step(10, 0, 0, 1, 1, 1, "crtn_empty");
        step(1, 12'h100, 1, 0, 1, 1, "cjs_fail");
        step(10, 0, 1, 0, 1, 1, "crtn_fail");

        // Counted loop via RFCT, then RLD_N reload during RFCT.
        step(12, 3, 1, 1, 1, 1, "ldct");
        step(4, 3, 1, 0, 1, 1, "push");
        for (int k = 0; k < 4; k++) step(8, 0, 1, 1, 1, 1, "rfct");
        step(12, 2, 1, 1, 1, 1, "ldct2");
        step(4, 0, 1, 0, 1, 1, "push2");
        step(8, 12'h007, 1, 1, 1, 0, "rfct_rld");
        for (int k = 0; k < 8; k++) step(8, 0, 1, 1, 1, 1, "rfct_after");

        // Stack fill, overflow, clear, and empty pop.
        for (int k = 0; k < 6; k++) step(1, 12'h200 + k, 0, 0, 1, 1, "fill");
        step(14, 0, 1, 1, 1, 1, "full_hold");
        step(0, 0, 1, 0, 1, 1, "jz");
        step(10, 0, 0, 0, 1, 1, "crtn_after_jz");
        step(14, 0, 1, 1, 1, 1, "empty_hold");

        // Every instruction code with alternating condition.
        for (int k = 0; k < 16; k++) step(k, 12'h300 + k, k[0], 0, 1, 1, "enables");

        // Two-way branch: R=2, three failures, then a pass.
        step(0, 0, 1, 1, 1, 1, "twb_jz");
        step(12, 2, 1, 1, 1, 1, "twb_ldct");
        step(4, 0, 1, 0, 1, 1, "twb_push");
        for (int k = 0; k < 3; k++) step(15, 12'h3F0, 1, 0, 1, 1, "twb_fail");
        step(4, 0, 1, 0, 1, 1, "twb_push2");
        step(15, 12'h3F0, 0, 0, 1, 1, "twb_pass");

        // Reset in the middle of a loop.
        step(12, 5, 1, 1, 1, 1, "mid_ldct");
        step(4, 0, 1, 0, 1, 1, "mid_push");
        step(8, 0, 1, 1, 1, 1, "mid_rfct");
        async_reset_probe("mid_reset");
        step(14, 0, 1, 1, 1, 1, "post_reset");

        // Randomized program.
        for (int n = 0; n < 400; n++) begin
            int i;
            i = int'($urandom_range(0, 15));
            if (i == 0 && $urandom_range(0, 3) != 0) i = 14;
            step(i, int'($urandom_range(0, MASK)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 7) != 0), "rand");
            if ($urandom_range(0, 99) == 0) async_reset_probe("rand_reset");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
